// File: rtl/ap_batch_sequencer.sv
// ap_batch_sequencer
//   Host-side job sequencer for the associative processor. One job does this:
//   clear every AP bank, stream CELL_QUANT operand pairs into columns A and B,
//   run a single AP command, wait for the compute-complete interrupt, and
//   stream column C back out.
//
// Ports
//   CLK100MHZ, rst            clock, asynchronous active-high reset
//   start, cmd                job request (sampled only in IDLE) and opcode
//   busy, done, error         job status; error is only meaningful with done
//   s_valid/s_ready/s_data_*  operand pair stream (one pair per row)
//   m_valid/m_ready/m_data    result stream, m_last marks row CELL_QUANT-1
//   ap_*                      AP control/data bus, ap_data_out and
//                             ap_state_irq come back from the AP
module ap_batch_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int NUM_BANKS  = 2,
    parameter int READ_LAT   = 1,
    parameter int MAX_CMD    = 6,
    parameter int TIMEOUT    = 4096,
    localparam int AW = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cmd,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_data_a,
    input  logic [WORD_SIZE-1:0] s_data_b,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_last,
    output logic [AW-1:0]        ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    localparam int BW = $clog2(NUM_BANKS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(READ_LAT + 1);

    localparam logic [AW-1:0] LAST_ROW  = AW'(CELL_QUANT - 1);
    localparam logic [BW-1:0] BANK_END  = BW'(NUM_BANKS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LAT - 1);
    // cmd is only 3 bits, so any limit above 8 accepts every opcode
    localparam logic [3:0]    CMD_LIMIT = (MAX_CMD > 8) ? 4'd8 : 4'(MAX_CMD);

    typedef enum logic [3:0] {
        IDLE, CLEAR, LD_WAIT, WR_A, WR_B, COMPUTE, RD_ISSUE, RD_WAIT, RD_HOLD, FIN
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0]        row;
    logic [BW-1:0]        bank;
    logic [TW-1:0]        tmo_cnt;
    logic [LW-1:0]        lat_cnt;
    logic [2:0]           cmd_q;
    logic [WORD_SIZE-1:0] a_q, b_q, m_data_q;
    logic                 irq_p1;
    logic                 rej_q;
    logic                 err_q;

    logic cmd_ok, irq_rise, bank_clr, tmo_hit, lat_hit, last_row;

    assign cmd_ok   = ({1'b0, cmd} < CMD_LIMIT);
    // Edge against the previous cycle's level, so an irq that is already high
    // when COMPUTE is entered does not count as completion.
    assign irq_rise = ap_state_irq & ~irq_p1;
    assign bank_clr = (state == CLEAR) && (bank != BANK_END);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign lat_hit  = (lat_cnt == LAT_LAST);
    assign last_row = (row == LAST_ROW);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            bank     <= '0;
            tmo_cnt  <= '0;
            lat_cnt  <= '0;
            cmd_q    <= '0;
            irq_p1   <= 1'b0;
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
            m_data_q <= '0;
        end else begin
            state  <= state_nx;
            irq_p1 <= ap_state_irq;
            rej_q  <= (state == IDLE) && start && !cmd_ok;
            case (state)
                IDLE: begin
                    if (start && cmd_ok) begin
                        cmd_q <= cmd;
                        bank  <= '0;
                        row   <= '0;
                        err_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (bank != BANK_END) bank <= bank + BW'(1);
                end
                WR_B: begin
                    tmo_cnt <= '0;
                    if (!last_row) row <= row + AW'(1);
                end
                COMPUTE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (irq_rise) row <= '0;
                    else if (tmo_hit) err_q <= 1'b1;
                end
                RD_ISSUE: lat_cnt <= '0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + LW'(1);
                    if (lat_hit) m_data_q <= ap_data_out;
                end
                RD_HOLD: begin
                    if (m_ready && !last_row) row <= row + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Operand pair holding registers: pure data, no reset needed.
    always_ff @(posedge CLK100MHZ) begin
        if (state == LD_WAIT && s_valid) begin
            a_q <= s_data_a;
            b_q <= s_data_b;
        end
    end

    always_comb begin
        state_nx            = state;
        busy                = (state != IDLE);
        done                = rej_q;
        error               = rej_q;
        s_ready             = 1'b0;
        m_valid             = 1'b0;
        m_last              = 1'b0;
        m_data              = m_data_q;
        ap_addr             = '0;
        ap_data             = '0;
        ap_rst              = rst | bank_clr;
        ap_mode             = 1'b0;
        ap_cmd              = 3'd0;
        ap_sel_col          = 2'd0;
        ap_sel_internal_col = bank_clr ? bank[0] : 1'b0;
        ap_write_en         = 1'b0;
        ap_read_en          = 1'b0;
        case (state)
            IDLE: begin
                if (start && cmd_ok) state_nx = CLEAR;
            end
            CLEAR: begin
                if (bank == BANK_END) state_nx = LD_WAIT;
            end
            LD_WAIT: begin
                s_ready = 1'b1;
                if (s_valid) state_nx = WR_A;
            end
            WR_A: begin
                ap_write_en = 1'b1;
                ap_sel_col  = 2'd0;
                ap_data     = a_q;
                ap_addr     = row;
                state_nx    = WR_B;
            end
            WR_B: begin
                ap_write_en = 1'b1;
                ap_sel_col  = 2'd1;
                ap_data     = b_q;
                ap_addr     = row;
                state_nx    = last_row ? COMPUTE : LD_WAIT;
            end
            COMPUTE: begin
                ap_mode = 1'b1;
                ap_cmd  = cmd_q;
                if (irq_rise) state_nx = RD_ISSUE;
                else if (tmo_hit) state_nx = FIN;
            end
            RD_ISSUE: begin
                ap_read_en = 1'b1;
                ap_sel_col = 2'd2;
                ap_addr    = row;
                state_nx   = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_hit) state_nx = RD_HOLD;
            end
            RD_HOLD: begin
                m_valid = 1'b1;
                m_last  = last_row;
                if (m_ready) state_nx = last_row ? FIN : RD_ISSUE;
            end
            FIN: begin
                done     = 1'b1;
                error    = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
